// File: rtl/dbg_pkg.sv
// dbg_pkg: shared FSM encoding and constants for the register-file dump scanner
package dbg_pkg;
   typedef enum logic [2:0] {IDLE, HDR, SEL, SEND, FIN} state_t;
   localparam logic [31:0] NO_PC       = 32'hFFFF_FFFF;
   localparam logic [31:0] DEF_STOP_PC = 32'h0000_0128;
endpackage

// File: rtl/regfile_dump_scanner.sv
// regfile_dump_scanner: halts the CPU, scans rf[0..NREGS-1] through the debug port
// and streams a PC header plus one word per register over valid/ready
module regfile_dump_scanner
   import dbg_pkg::*;
#(
   parameter logic [31:0] STOP_PC = DEF_STOP_PC,
   parameter int          NREGS   = 32,
   parameter int          SETTLE  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   input  logic        arm,
   input  logic        dump_req,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_data,
   output logic        halt_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_hdr,
   output logic [4:0]  out_idx,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic [7:0]  dump_cnt
);
   localparam logic [4:0] LAST = 5'(NREGS - 1);
   state_t      state_q;
   logic [4:0]  idx_q, reg_sel_q, out_idx_q;
   logic [2:0]  cnt_q;
   logic [31:0] out_data_q;
   logic [7:0]  dump_cnt_q;
   logic        halt_q, valid_q, hdr_q, last_q, busy_q, done_q;
   logic        trig;
   assign trig      = dump_req | (arm & pc_valid & (pc_in == STOP_PC));
   assign reg_sel   = reg_sel_q;
   assign halt_req  = halt_q;
   assign out_valid = valid_q;
   assign out_data  = out_data_q;
   assign out_hdr   = hdr_q;
   assign out_idx   = out_idx_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dump_cnt  = dump_cnt_q;
   // reg_sel is loaded on entry to SEL, so it is stable for SETTLE+1 cycles before capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         reg_sel_q  <= '0;
         out_idx_q  <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         dump_cnt_q <= '0;
         halt_q     <= 1'b0;
         valid_q    <= 1'b0;
         hdr_q      <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (trig) begin
               state_q    <= HDR;
               out_data_q <= pc_valid ? pc_in : NO_PC;
               out_idx_q  <= '0;
               valid_q    <= 1'b1;
               hdr_q      <= 1'b1;
               halt_q     <= 1'b1;
               busy_q     <= 1'b1;
            end
            HDR: if (out_ready) begin
               state_q   <= SEL;
               valid_q   <= 1'b0;
               hdr_q     <= 1'b0;
               idx_q     <= '0;
               reg_sel_q <= '0;
               cnt_q     <= '0;
            end
            SEL: if (cnt_q == 3'(SETTLE)) begin
               state_q    <= SEND;
               out_data_q <= (idx_q == '0) ? '0 : reg_data;
               out_idx_q  <= idx_q;
               last_q     <= idx_q == LAST;
               valid_q    <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 3'd1;
            end
            SEND: if (out_ready) begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               if (last_q) begin
                  state_q    <= FIN;
                  done_q     <= 1'b1;
                  halt_q     <= 1'b0;
                  dump_cnt_q <= (dump_cnt_q == 8'hFF) ? dump_cnt_q : dump_cnt_q + 8'd1;
               end else begin
                  state_q   <= SEL;
                  idx_q     <= idx_q + 5'd1;
                  reg_sel_q <= idx_q + 5'd1;
                  cnt_q     <= '0;
               end
            end
            FIN: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_dump_scanner.sv
// tb_regfile_dump_scanner: directed checks of the dump scanner (SETTLE=1 and SETTLE=3 builds)
module tb_regfile_dump_scanner;
   typedef struct packed {logic [31:0] d; logic h; logic [4:0] i; logic l;} word_t;
   logic        clk = 0, rst = 1;
   logic [31:0] pc_in = 0;
   logic        pc_valid = 0, arm = 0, dump_req = 0, dump_req3 = 0, rnd_en = 0, rnd_r = 1;
   logic [4:0]  reg_sel, out_idx, reg_sel3, out_idx3;
   logic [31:0] reg_data, out_data, reg_data3, out_data3;
   logic        halt_req, out_valid, out_ready, out_hdr, out_last, busy, done;
   logic        halt_req3, out_valid3, out_hdr3, out_last3, busy3, done3;
   logic [7:0]  dump_cnt, dump_cnt3;
   int          checks = 0, fails = 0, done_n = 0, w3 = 0, st3 = 0, min_st = 99;
   logic        stall_p = 0, pv3 = 0;
   logic [42:0] sv_p = 0;
   logic [4:0]  rs_p = 0;
   word_t       q[$];
   always #5 clk = ~clk;
   assign reg_data  = 32'(reg_sel) * 32'h11;
   assign reg_data3 = 32'(reg_sel3) * 32'h11;
   assign out_ready = rnd_en ? rnd_r : 1'b1;
   always @(posedge clk) rnd_r <= 1'($urandom_range(0, 1));
   regfile_dump_scanner u_dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .arm(arm), .dump_req(dump_req),
      .reg_sel(reg_sel), .reg_data(reg_data), .halt_req(halt_req), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_hdr(out_hdr), .out_idx(out_idx),
      .out_last(out_last), .busy(busy), .done(done), .dump_cnt(dump_cnt));
   regfile_dump_scanner #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .arm(1'b0), .dump_req(dump_req3),
      .reg_sel(reg_sel3), .reg_data(reg_data3), .halt_req(halt_req3), .out_valid(out_valid3),
      .out_ready(1'b1), .out_data(out_data3), .out_hdr(out_hdr3), .out_idx(out_idx3),
      .out_last(out_last3), .busy(busy3), .done(done3), .dump_cnt(dump_cnt3));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // stream collector and stall-stability monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) stall_p = 0;
      else begin
         if (stall_p) chk("stall_hold", {out_valid, out_data, out_idx, out_last, reg_sel}, {1'b1, sv_p});
         if (out_valid && out_ready) q.push_back('{out_data, out_hdr, out_idx, out_last});
         if (done) done_n++;
         stall_p = out_valid && !out_ready;
         sv_p = {out_data, out_idx, out_last, reg_sel};
      end
   end
   always @(negedge clk) begin
      if (out_valid3 && !pv3) min_st = (st3 < min_st) ? st3 : min_st;
      st3 = (reg_sel3 == rs_p) ? st3 + 1 : 1;
      rs_p = reg_sel3;
      pv3 = out_valid3;
      if (out_valid3) w3++;
   end
   task automatic pulse_req();
      @(posedge clk); #1 dump_req = 1;
      @(posedge clk); #1 dump_req = 0;
   endtask
   task automatic wait_done(input int d0);
      for (int k = 0; k < 1000 && done_n == d0; k++) @(negedge clk);
      chk("done_timeout", 64'(done_n > d0), 1);
   endtask
   task automatic check_dump(input string tag, input int base, input logic [31:0] hdr);
      int errs;
      word_t w;
      chk({tag, "_nwords"}, 64'(q.size() - base), 33);
      if (q.size() - base == 33) begin
         errs = 0;
         for (int i = 0; i < 32; i++) begin
            w = q[base + 1 + i];
            if (w.d !== ((i == 0) ? 32'h0 : 32'(i) * 32'h11) || w.i !== 5'(i) || w.l !== (i == 31) || w.h) errs++;
         end
         chk({tag, "_words"}, 64'(errs), 0);
         chk({tag, "_hdr"}, {q[base].h, q[base].i, q[base].d}, {1'b1, 5'd0, hdr});
         chk({tag, "_rf5"}, q[base + 6].d, 32'h55);
      end
   endtask
   initial begin
      int base, d0, cyc;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst_outs", {out_valid, halt_req, busy, done, out_hdr, out_last, out_idx, reg_sel, dump_cnt},
          0);
      chk("rst_data", out_data, 0);
      // 1: manual dump, no valid PC
      base = q.size(); d0 = done_n;
      pulse_req();
      chk("t1_halt", {halt_req, busy}, 2'b11);
      wait_done(d0);
      check_dump("t1", base, 32'hFFFF_FFFF);
      chk("t1_done_once", 64'(done_n - d0), 1);
      chk("t1_cnt", dump_cnt, 1);
      // 2: armed stop-PC hit
      base = q.size(); d0 = done_n;
      @(posedge clk); #1 arm = 1; pc_valid = 1; pc_in = 32'h124;
      @(posedge clk); #1 chk("t2_nohalt", halt_req, 0); pc_in = 32'h128;
      @(posedge clk); #1 chk("t2_halt", halt_req, 1); pc_valid = 0; arm = 0;
      wait_done(d0);
      @(posedge clk); #1 chk("t2_release", {halt_req, busy}, 0);
      check_dump("t2", base, 32'h128);
      chk("t2_cnt", dump_cnt, 2);
      // 3: random backpressure
      base = q.size(); d0 = done_n;
      rnd_en = 1;
      pulse_req();
      wait_done(d0);
      rnd_en = 0;
      check_dump("t3", base, 32'hFFFF_FFFF);
      chk("t3_cnt", dump_cnt, 3);
      // 4: triggers while busy are dropped; disarmed stop-PC is ignored
      base = q.size(); d0 = done_n;
      pulse_req();
      for (int k = 0; k < 3; k++) begin
         repeat (15) @(posedge clk);
         pulse_req();
      end
      wait_done(d0);
      repeat (10) @(posedge clk);
      #1 chk("t4_idle", busy, 0);
      chk("t4_cnt", dump_cnt, 4);
      chk("t4_one_done", 64'(done_n - d0), 1);
      check_dump("t4", base, 32'hFFFF_FFFF);
      pc_valid = 1; pc_in = 32'h128;
      repeat (5) @(posedge clk);
      #1 chk("t4_disarmed", {busy, halt_req}, 0);
      pc_valid = 0;
      // 5: reset mid-dump after idx 10 transfers
      base = q.size(); d0 = done_n;
      pulse_req();
      for (int k = 0; k < 1000 && q.size() - base < 12; k++) @(negedge clk);
      chk("t5_reach10", 64'(q.size() - base), 12);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1
      chk("t5_rst_outs", {out_valid, halt_req, busy, done, out_last, out_hdr, dump_cnt}, 0);
      rst = 0;
      repeat (3) @(posedge clk);
      chk("t5_no_done", 64'(done_n - d0), 0);
      base = q.size(); d0 = done_n;
      pulse_req();
      wait_done(d0);
      check_dump("t5", base, 32'hFFFF_FFFF);
      chk("t5_cnt", dump_cnt, 1);
      // 6: SETTLE=3 build timing
      base = w3; cyc = 0;
      @(posedge clk); #1 dump_req3 = 1;
      @(posedge clk); #1 dump_req3 = 0;
      for (int k = 0; k < 1000 && (cyc == 0 || busy3); k++) begin
         @(negedge clk);
         if (busy3) cyc++;
      end
      chk("t6_cycles", 64'(cyc), 162);
      chk("t6_words", 64'(w3 - base), 33);
      chk("t6_settle", 64'(min_st >= 3), 1);
      chk("t6_cnt", dump_cnt3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
